// File: rtl/sdio_pkg.sv
// sdio_pkg: command indices, status bit positions and state types for the SDIO command layer.
package sdio_pkg;
  localparam logic [5:0] CMD_GO_IDLE = 6'h00;
  localparam logic [5:0] CMD_STATUS = 6'h0D;
  localparam logic [5:0] CMD_REG = 6'h34;
  localparam logic [5:0] CMD_ID = 6'h3F;
  localparam int ST_ILLEGAL = 0;
  localparam int ST_TIMEOUT = 1;
  localparam int ST_OVERRUN = 2;
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} card_state_t;
  typedef enum logic [1:0] {S_WAIT = 2'd0, S_REG = 2'd1, S_RESP = 2'd2} fsm_t;
endpackage

// File: rtl/sdio_cmd_ctrl.sv
// sdio_cmd_ctrl: SDIO command-layer controller bridging REG commands to a register file.
// Define SDIO_CMD_TIMEOUT_EN to abort register accesses that are not acked within TIMEOUT_CYC cycles.
module sdio_cmd_ctrl
  import sdio_pkg::*;
#(
  parameter logic [31:0] CARD_ID = 32'hF00FF00F,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [5:0]  req_cmd,
  input  logic [31:0] req_arg,
  output logic        resp_valid,
  output logic [31:0] resp_arg,
  output logic        resp_skip,
  output logic        reg_req,
  output logic        reg_we,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  input  logic        reg_ack,
  input  logic [15:0] reg_rdata
);
  fsm_t fsm;
  card_state_t card_state;
  logic [2:0] status, snap, ovr_bit, tmo_bit;
  logic ovr, done, tmo;
  logic unused_arg;
  assign unused_arg = ^req_arg[30:24];
  assign ovr = req_valid && fsm != S_WAIT;
  assign ovr_bit = ovr ? 3'b100 : 3'b000;
  assign tmo_bit = tmo ? 3'b010 : 3'b000;
  assign done = fsm == S_REG && (reg_ack || tmo);
`ifdef SDIO_CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] cnt;
  // an ack in the expiry cycle takes priority over the abort
  assign tmo = fsm == S_REG && !reg_ack && cnt == CW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk)
    if (!rst_n || fsm != S_REG) cnt <= '0;
    else cnt <= cnt + 1'b1;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYC;
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm <= S_WAIT;
      card_state <= IDLE;
      status <= '0;
      snap <= '0;
      resp_valid <= 1'b0;
      resp_skip <= 1'b0;
      resp_arg <= '0;
      reg_req <= 1'b0;
      reg_we <= 1'b0;
      reg_addr <= '0;
      reg_wdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_skip <= 1'b0;
      status <= status | ovr_bit;
      case (fsm)
        S_WAIT:
          if (req_valid) begin
            if (req_cmd == CMD_GO_IDLE) begin
              resp_skip <= 1'b1;
              card_state <= IDLE;
              status <= '0;
            end else if (req_cmd == CMD_ID) begin
              resp_valid <= 1'b1;
              resp_arg <= CARD_ID;
              card_state <= ACTIVE;
            end else if (req_cmd == CMD_STATUS) begin
              resp_valid <= 1'b1;
              resp_arg <= {5'b0, status, 7'b0, card_state, 16'h0000};
              status <= '0;
            end else if (req_cmd == CMD_REG && card_state == ACTIVE) begin
              reg_req <= 1'b1;
              reg_we <= req_arg[31];
              reg_addr <= req_arg[23:16];
              reg_wdata <= req_arg[15:0];
              snap <= status;
              fsm <= S_REG;
            end else begin
              resp_skip <= 1'b1;
              status[ST_ILLEGAL] <= 1'b1;
            end
          end
        S_REG:
          if (done) begin
            reg_req <= 1'b0;
            resp_valid <= 1'b1;
            resp_arg <= {5'b0, snap, reg_addr, tmo ? 16'h0000 : reg_we ? reg_wdata : reg_rdata};
            // only the bits actually reported are cleared; errors raised meanwhile stay
            status <= (status & ~snap) | ovr_bit | tmo_bit;
            fsm <= S_RESP;
          end
        S_RESP: fsm <= S_WAIT;
        default: fsm <= S_WAIT;
      endcase
    end
  end
endmodule
